// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, debounce FSM and auto-repeat timer.
// Raw btnx is low-active; every output is registered in the clk domain.
module button_debouncer #(
    parameter int CLK_FREQ_KHZ  = 24000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int REPEAT_DLY_MS = 500,
    parameter int REPEAT_PER_MS = 100,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnx,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DEB_RAW = CLK_FREQ_KHZ * DEBOUNCE_MS;
    localparam int DLY_RAW = CLK_FREQ_KHZ * REPEAT_DLY_MS;
    localparam int PER_RAW = CLK_FREQ_KHZ * REPEAT_PER_MS;
    // Repeat intervals of at least 2 keep strobes from landing back-to-back.
    localparam int DEB_CYC = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int RPT_DLY = (DLY_RAW < 2) ? 2 : DLY_RAW;
    localparam int RPT_PER = (PER_RAW < 2) ? 2 : PER_RAW;
    localparam int MAX_AB  = (DEB_CYC > RPT_DLY) ? DEB_CYC : RPT_DLY;
    localparam int CMAX    = (MAX_AB > RPT_PER) ? MAX_AB : RPT_PER;
    localparam int CW      = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] rpt_end;
    logic armed_q, armed_d;
    logic level_d, press_d, release_d;
    logic s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btnx};
        end
    end

    assign s = ~sync_q[SYNC_STAGES-1];

    // armed: the initial hold delay has elapsed, so the shorter period applies.
    assign rpt_end = armed_q ? CW'(RPT_PER - 1) : CW'(RPT_DLY - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            armed_q     <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            armed_q     <= armed_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        armed_d   = armed_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEB_CYC - 1)) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    armed_d = 1'b0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    rcnt_d  = '0;
                    armed_d = 1'b0;
                end else if (rcnt_q == rpt_end) begin
                    rcnt_d  = '0;
                    armed_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A bounce back to pressed resumes the repeat timer where it was.
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEB_CYC - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
